fetch_queue: RTL and testbench

//  Instruction-fetch front end, directly upstream of the instruction memory.
//  - Owns the fetch PC and drives it to the instruction memory.
//  - Captures the returned word, with its PC, into a small FIFO.
//  - Presents fetched instructions to decode over a valid/ready handshake.
//  - A redirect (branch/jump/trap target) flushes the queue and restarts fetch.

---
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, queues returned words with their PC, and hands them to decode.
// Optional misaligned-redirect trap with HALT state is compiled in by defining FETCH_ALIGN_CHECK_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic [CNT_W-1:0] occupancy,
  output logic             misalign_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [31:0]       fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              halted;
  logic              push;
  logic              pop;
  logic              not_full;
  logic [31:0]       redirect_aligned;
  entry_t            head;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic {RUN, HALT} state_t;

  state_t state;
  logic   fault;

  // Misaligned redirect traps into HALT; only an aligned redirect (or reset) resumes fetch.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state <= RUN;
      fault <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state <= HALT;
        fault <= 1'b1;
      end else begin
        state <= RUN;
        fault <= 1'b0;
      end
    end
  end

  assign halted         = (state == HALT);
  assign misalign_fault = fault;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted               = 1'b0;
  assign misalign_fault       = 1'b0;
`endif

  // Handshake qualifiers; a redirect masks both sides of the queue.
  assign not_full  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ~halted & (not_full | pop);

  assign head         = mem[rd_ptr];
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc + 32'd4;
  assign occupancy    = count;
  assign imem_pc      = fetch_pc;

  // Storage is intentionally not reset; contents are only observed behind out_valid.
  always_ff @(posedge SYS_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
    end
  end

  // Fetch PC, pointers and occupancy; redirect takes priority over everything.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected PCs, a negedge monitor checks each accepted word.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  occupancy;
  logic        misalign_fault;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Instruction memory model: word tagged with its own address.
  assign imem_instr = 32'h1000_0000 | imem_pc;

  fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4),
    .CNT_W   (3)
  ) dut (
    .SYS_clk       (clk),
    .SYS_reset     (rst),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .occupancy     (occupancy),
    .misalign_fault(misalign_fault)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every accepted head entry must match the next queued expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got pc %h expected no transfer at %0t", out_pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_instr", out_instr, 32'h1000_0000 | e);
        chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
      end
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic reset_release(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = rdy;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    rst = 1'b1;
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Reset state
    sample();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_fault", 32'(misalign_fault), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'h0);

    // Streaming from reset with decode always ready
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    reset_release(1'b1);
    sample();
    chk("t1_first_cycle_valid", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive();
      sample();
    end
    drive();
    end_test("t1_drained");
    sample();
    chk("t1_reset_occupancy", 32'(occupancy), 32'd0);
    chk("t1_reset_imem_pc", imem_pc, 32'h0);

    // Back-pressure fills the queue, then full-with-pop keeps it full
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    reset_release(1'b0);
    drive();
    sample();
    chk("t2_occ_1", 32'(occupancy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive();
      sample();
    end
    chk("t2_occ_full", 32'(occupancy), 32'd4);
    chk("t2_pc_frozen", imem_pc, 32'h10);
    for (int k = 0; k < 5; k++) begin
      drive();
      sample();
    end
    chk("t2_occ_hold", 32'(occupancy), 32'd4);
    chk("t2_pc_still_frozen", imem_pc, 32'h10);
    drive();
    out_ready = 1'b1;
    sample();
    chk("t3_occ_0", 32'(occupancy), 32'd4);
    for (int k = 1; k <= 3; k++) begin
      drive();
      sample();
      chk("t3_occ_steady", 32'(occupancy), 32'd4);
      chk("t3_imem_pc_adv", imem_pc, 32'h10 + 32'(4 * k));
    end
    drive();
    sample();
    drive();
    end_test("t2_drained");

    // Redirect while three entries are queued
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    reset_release(1'b0);
    drive();
    drive();
    drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    sample();
    chk("t4_valid_masked", 32'(out_valid), 32'd0);
    chk("t4_occ_before", 32'(occupancy), 32'd3);
    drive();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sample();
    chk("t4_occ_flushed", 32'(occupancy), 32'd0);
    chk("t4_valid_flushed", 32'(out_valid), 32'd0);
    chk("t4_imem_pc", imem_pc, 32'h200);
    drive();
    sample();
    drive();
    sample();
    drive();
    end_test("t4_drained");

    // Back-to-back redirects, last wins, and PC wraps through zero
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    reset_release(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    drive();
    redirect_pc = 32'hFFFF_FFF8;
    sample();
    chk("t5_valid_b2b", 32'(out_valid), 32'd0);
    chk("t5_occ_b2b", 32'(occupancy), 32'd0);
    drive();
    redirect_valid = 1'b0;
    sample();
    chk("t5_imem_pc", imem_pc, 32'hFFFF_FFF8);
    chk("t5_occ_empty", 32'(occupancy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive();
      sample();
    end
    drive();
    end_test("t5_drained");

    // Misaligned redirect
    reset_release(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    drive();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t6_fault_set", 32'(misalign_fault), 32'd1);
      chk("t6_halt_no_valid", 32'(out_valid), 32'd0);
      chk("t6_halt_occ", 32'(occupancy), 32'd0);
      drive();
    end
    exp_q.push_back(32'h300);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    sample();
    drive();
    redirect_valid = 1'b0;
    sample();
    chk("t6_fault_cleared", 32'(misalign_fault), 32'd0);
    chk("t6_occ_after_clear", 32'(occupancy), 32'd0);
    drive();
    sample();
    chk("t6_fault_stays_clear", 32'(misalign_fault), 32'd0);
    drive();
`else
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    sample();
    chk("t6_fault_tied", 32'(misalign_fault), 32'd0);
    chk("t6_imem_pc_aligned", imem_pc, 32'h100);
    drive();
    sample();
    drive();
    sample();
    chk("t6_fault_still_0", 32'(misalign_fault), 32'd0);
    drive();
`endif
    end_test("t6_drained");

    sample();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
